req_priority_encoder: RTL



---
 rtl/req_priority_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/req_priority_encoder.sv
// Registered 8-to-3 priority encoder with valid/ack handshake.
// Requests are active-low and asynchronous; bit 7 has the highest priority.
// A captured code is held until acknowledged. The acknowledged line is then
// masked until it has been seen released for at least one cycle.
module req_priority_encoder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       EnN,
    input  logic [7:0] ReqN,
    input  logic       Ack,
    output logic [2:0] Code,
    output logic       Valid,
    output logic       GsN,
    output logic       EoN
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    logic [N_REQ-1:0]  sync_q [SYNC_STAGES];
    logic [N_REQ-1:0]  req_s;
    logic [N_REQ-1:0]  act;
    logic [N_REQ-1:0]  ack_hit;
    logic [N_REQ-1:0]  served_q, served_d;
    logic [CODE_W-1:0] top_code;

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              gsn_q, gsn_d;
    logic              eon_q, eon_d;

    // Multi-flop synchroniser for the asynchronous request lines (idle high)
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= ReqN;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign act   = ~req_s & ~served_q;

    // Line currently being acknowledged (one-hot, only while holding)
    always_comb begin
        ack_hit = '0;
        if (state_q == HOLD && Ack) begin
            ack_hit[code_q] = 1'b1;
        end
    end

    // A line stays masked after its ack until it is seen released
    assign served_d = ~req_s & (served_q | ack_hit);

    // Highest-numbered active line; later iterations override lower ones
    always_comb begin
        top_code = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (act[i]) begin
                top_code = CODE_W'(i);
            end
        end
    end

    // Capture/hold handshake plus group-select and enable-out flags
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        gsn_d   = EnN | (&req_s);
        eon_d   = EnN | ~(&req_s);
        unique case (state_q)
            IDLE: begin
                if (!EnN && (|act)) begin
                    code_d  = top_code;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, mask and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            served_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            gsn_q    <= 1'b1;
            eon_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            gsn_q    <= gsn_d;
            eon_q    <= eon_d;
        end
    end

    assign Code  = code_q;
    assign Valid = valid_q;
    assign GsN   = gsn_q;
    assign EoN   = eon_q;

endmodule
